run_detector: RTL and testbench
===============================

RUN_DETECTOR -- requirements
Module: run_detector

Interface
REQ-001 Parameter CH, default 4: number of independent input channels (1..16).
REQ-002 Parameter CNT_W, default 4: run-counter width per channel; saturation value is 2^CNT_W-1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  sample enable; when low, all channel state holds.
REQ-006 mode  input  2  run type: 00 ones, 01 zeros, 10 either value, 11 disabled.
REQ-007 thresh  input  CNT_W  run length that asserts detection; 0 disables detection.
REQ-008 w  input  CH  per-channel serial data input, sampled when en=1.
REQ-009 z  output  CH  per-channel level: high while the current run length is >= thresh.
REQ-010 det  output  CH  per-channel one-cycle pulse: the run length has just reached thresh.
REQ-011 run_len  output  CH*CNT_W  per-channel current run count; channel i occupies bits [i*CNT_W +: CNT_W].

Function
REQ-012 Each channel SHALL hold registers last_w (1b), seen (1b), cnt (CNT_W), z, det; channels are fully independent.
REQ-013 Match rule for a sample with en=1:
  - mode 00: w=1.
  - mode 01: w=0.
  - mode 10: seen=1 and w=last_w.
REQ-014 On a sample with en=1:
  - match: cnt <= min(cnt+1, 2^CNT_W-1).
  - no match: cnt <= 1 in mode 10, 0 in modes 00/01.
  - always: last_w <= w, seen <= 1.
REQ-015 cnt SHALL saturate, never wrap; z SHALL stay high across saturation.
REQ-016 z SHALL be registered: z <= (thresh != 0) and (cnt_next >= thresh), evaluated on every edge with en=1.
REQ-017 Latency: z rises on the same edge that samples the thresh-th consecutive matching value (e.g. thresh=4, mode 00: high after the 4th edge sampling w=1).
REQ-018 Overlapping runs: z stays high for every further matching sample and drops on the edge that samples the first non-matching value.
REQ-019 det SHALL be high for exactly one cycle when cnt_next = thresh and cnt < thresh, and low otherwise; det is low in any cycle following an edge with en=0.
REQ-020 en=0: cnt, last_w, seen and z hold; det <= 0.
REQ-021 mode 11: cnt, seen, z and det SHALL be cleared on the next edge, regardless of en.
REQ-022 A change of mode or thresh between consecutive edges SHALL clear cnt, seen, z and det on that edge; counting restarts with the next sample. The block registers mode and thresh internally to detect the change.
REQ-023 run_len SHALL present cnt directly from the register, with no added latency.

Reset
REQ-024 While rst=0, asynchronously: cnt=0, last_w=0, seen=0, z=0, det=0 for all channels; the internal mode/thresh copies load 11 and 0.
REQ-025 Reset asserted mid-run SHALL take effect immediately, without waiting for clk; the first edge after release treats w as a first sample.

Structure
REQ-026 Package run_det_pkg SHALL hold the mode encodings (MODE_ONES, MODE_ZEROS, MODE_EITHER, MODE_OFF) and the default CH and CNT_W values.
REQ-027 Per-channel logic SHALL be the sub-module run_det_ch, instantiated CH times by a generate loop; run_detector holds only the shared mode/thresh change detection and the output packing.

Verification
REQ-028 mode=00, thresh=4, ch0 w=1 for 6 cycles then 0 -> z[0] rises after the 4th edge and stays high for 3 cycles; det[0] pulses once after the 4th edge; run_len ch0 = 1,2,3,4,5,6,0.
REQ-029 mode=10, thresh=3, ch1 w=0,0,0,1,1,1 -> z[1] high after edge 3, low after edge 4, high again after edge 6; det[1] pulses twice.
REQ-030 CNT_W=4, mode=00, thresh=15, w=1 for 20 cycles -> run_len saturates at 15; z high from edge 15 onward; a single det pulse.
REQ-031 thresh=4 with en toggled 1,0,1,0,... while w=1 -> z rises after the 4th enabled edge; counts hold across en=0 cycles.
REQ-032 rst pulsed low asynchronously at run_len=3 -> all outputs are 0 before the next clk edge; the next w=1 edge gives run_len=1.
REQ-033 mode changed 00->01 mid-run at run_len=5, z=1 -> the next edge clears z and run_len; 4 following zeros assert z again.

Source files
------------

// File: rtl/run_det_pkg.sv
// Shared definitions for the run detector: run-type encodings and default sizes.
package run_det_pkg;

  localparam int CH_DEF    = 4;
  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    MODE_ONES   = 2'b00,
    MODE_ZEROS  = 2'b01,
    MODE_EITHER = 2'b10,
    MODE_OFF    = 2'b11
  } mode_e;

endpackage

// File: rtl/run_det_if.sv
// Control, serial data and result bundle of the run detector.
interface run_det_if #(
  parameter int CH    = 4,
  parameter int CNT_W = 4
);
  logic                en;
  logic [1:0]          mode;
  logic [CNT_W-1:0]    thresh;
  logic [CH-1:0]       w;
  logic [CH-1:0]       z;
  logic [CH-1:0]       det;
  logic [CH*CNT_W-1:0] run_len;

  modport master (output en, mode, thresh, w, input z, det, run_len);
  modport slave  (input en, mode, thresh, w, output z, det, run_len);
endinterface

// File: rtl/run_det_ch.sv
// One channel of the run detector: run counter, level and reach-pulse flags.
module run_det_ch
  import run_det_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic [CNT_W-1:0] thresh_i,
  input  logic             clr_i,
  input  logic             w_i,
  output logic             z_o,
  output logic             det_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             last_w_q, last_w_d;
  logic             seen_q, seen_d;
  logic             z_q, z_d;
  logic             det_q, det_d;
  logic             match;

  // Next-state: match the sample, advance or restart the run, derive z/det.
  always_comb begin
    cnt_d    = cnt_q;
    last_w_d = last_w_q;
    seen_d   = seen_q;
    z_d      = z_q;
    det_d    = 1'b0;
    match    = 1'b0;
    cnt_inc  = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;

    case (mode_i)
      MODE_ONES:   match = w_i;
      MODE_ZEROS:  match = ~w_i;
      MODE_EITHER: match = seen_q && (w_i == last_w_q);
      default:     match = 1'b0;
    endcase

    if (clr_i || (mode_i == MODE_OFF)) begin
      cnt_d  = '0;
      seen_d = 1'b0;
      z_d    = 1'b0;
    end else if (en_i) begin
      // In either-value mode a breaking sample starts a new run of length 1.
      if (match)
        cnt_d = cnt_inc;
      else if (mode_i == MODE_EITHER)
        cnt_d = CNT_W'(1);
      else
        cnt_d = '0;
      z_d      = (thresh_i != '0) && (cnt_d >= thresh_i);
      det_d    = (thresh_i != '0) && (cnt_d == thresh_i) && (cnt_q < thresh_i);
      last_w_d = w_i;
      seen_d   = 1'b1;
    end
  end

  // Channel state register with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      last_w_q <= 1'b0;
      seen_q   <= 1'b0;
      z_q      <= 1'b0;
      det_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      last_w_q <= last_w_d;
      seen_q   <= seen_d;
      z_q      <= z_d;
      det_q    <= det_d;
    end
  end

  assign z_o   = z_q;
  assign det_o = det_q;
  assign cnt_o = cnt_q;

endmodule

// File: rtl/run_detector.sv
// Multi-channel run detector: shared mode/thresh change detection plus CH channels.
module run_detector
  import run_det_pkg::*;
#(
  parameter int CH    = CH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic     clk,
  input  logic     rst,
  run_det_if.slave bus
);

  logic [1:0]       mode_q;
  logic [CNT_W-1:0] thresh_q;
  logic             clr;

  // Remember the configuration seen at the previous edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q   <= MODE_OFF;
      thresh_q <= '0;
    end else begin
      mode_q   <= bus.mode;
      thresh_q <= bus.thresh;
    end
  end

  // Leaving the disabled mode is not treated as a change: the channels are
  // already cleared there, so the first sample afterwards counts. This also
  // makes the first edge after reset a genuine first sample.
  assign clr = (mode_q != MODE_OFF) &&
               ((bus.mode != mode_q) || (bus.thresh != thresh_q));

  for (genvar i = 0; i < CH; i++) begin : g_ch
    run_det_ch #(.CNT_W(CNT_W)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en_i     (bus.en),
      .mode_i   (bus.mode),
      .thresh_i (bus.thresh),
      .clr_i    (clr),
      .w_i      (bus.w[i]),
      .z_o      (bus.z[i]),
      .det_o    (bus.det[i]),
      .cnt_o    (bus.run_len[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_run_detector.sv
// Self-checking bench for run_detector: directed scenarios plus random traffic
// compared against a run-length reference model.
module tb_run_detector;

  localparam int CH    = 4;
  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic clk;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  run_det_if #(.CH(CH), .CNT_W(CNT_W)) bus ();

  run_detector #(.CH(CH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: run length per channel as a plain integer.
  int cnt_m  [CH];
  bit last_m [CH];
  bit seen_m [CH];
  bit z_m    [CH];
  bit det_m  [CH];
  int mode_p;
  int thr_p;

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      cnt_m[c] = 0; last_m[c] = 0; seen_m[c] = 0; z_m[c] = 0; det_m[c] = 0;
    end
    mode_p = 3;
    thr_p  = 0;
  endtask

  task automatic model_edge();
    int  m, t, old;
    bit  chg, wb, hit;
    m   = int'(bus.mode);
    t   = int'(bus.thresh);
    chg = (mode_p != 3) && ((m != mode_p) || (t != thr_p));
    for (int c = 0; c < CH; c++) begin
      wb = bus.w[c];
      if (m == 3 || chg) begin
        cnt_m[c] = 0; seen_m[c] = 0; z_m[c] = 0; det_m[c] = 0;
      end else if (bus.en) begin
        if (m == 0)      hit = wb;
        else if (m == 1) hit = !wb;
        else             hit = seen_m[c] && (wb == last_m[c]);
        old = cnt_m[c];
        if (hit)         cnt_m[c] = (old + 1 > SAT) ? SAT : old + 1;
        else             cnt_m[c] = (m == 2) ? 1 : 0;
        z_m[c]    = (t != 0) && (cnt_m[c] >= t);
        det_m[c]  = (t != 0) && (cnt_m[c] == t) && (old < t);
        last_m[c] = wb;
        seen_m[c] = 1;
      end else begin
        det_m[c] = 0;
      end
    end
    mode_p = m;
    thr_p  = t;
  endtask

  task automatic check(input string tag);
    logic [CH-1:0]       ez, ed;
    logic [CH*CNT_W-1:0] er;
    for (int c = 0; c < CH; c++) begin
      ez[c] = z_m[c];
      ed[c] = det_m[c];
      er[c*CNT_W +: CNT_W] = cnt_m[c][CNT_W-1:0];
    end
    tests++;
    assert (bus.z === ez) else begin
      fails++;
      $error("FAIL %s z observed=%b expected=%b", tag, bus.z, ez);
    end
    tests++;
    assert (bus.det === ed) else begin
      fails++;
      $error("FAIL %s det observed=%b expected=%b", tag, bus.det, ed);
    end
    tests++;
    assert (bus.run_len === er) else begin
      fails++;
      $error("FAIL %s run_len observed=%h expected=%h", tag, bus.run_len, er);
    end
  endtask

  task automatic step(input logic e, input logic [1:0] m, input int t,
                      input logic [CH-1:0] wv, input string tag);
    bus.en     = e;
    bus.mode   = m;
    bus.thresh = t[CNT_W-1:0];
    bus.w      = wv;
    @(posedge clk);
    model_edge();
    #1;
    check(tag);
  endtask

  initial begin
    int m_r, t_r;
    clk = 0;
    rst = 0;
    bus.en = 0; bus.mode = 2'b11; bus.thresh = '0; bus.w = '0;
    model_reset();
    #3;
    check("reset");
    @(posedge clk); #1;
    check("reset_clk");
    rst = 1;

    // Ones run on ch0, thresh 4, six ones then a zero.
    for (int i = 0; i < 6; i++) step(1, 2'b00, 4, 4'b0001, "ones_run");
    step(1, 2'b00, 4, 4'b0000, "ones_break");

    // Either-value runs on ch1, thresh 3 (first edge is a config-change clear).
    step(1, 2'b10, 3, 4'b0000, "either_cfg");
    step(1, 2'b10, 3, 4'b0000, "either_run");
    step(1, 2'b10, 3, 4'b0000, "either_run");
    step(1, 2'b10, 3, 4'b0000, "either_run");
    step(1, 2'b10, 3, 4'b0010, "either_run");
    step(1, 2'b10, 3, 4'b0010, "either_run");
    step(1, 2'b10, 3, 4'b0010, "either_run");

    // Saturation at thresh 15.
    step(1, 2'b00, 15, 4'b0000, "sat_cfg");
    for (int i = 0; i < 20; i++) step(1, 2'b00, 15, 4'b1111, "sat_run");
    tests++;
    assert (bus.run_len === {CH{4'hF}}) else begin
      fails++;
      $error("FAIL sat_value run_len observed=%h expected=%h", bus.run_len, {CH{4'hF}});
    end

    // Enable toggling, thresh 4.
    step(1, 2'b00, 4, 4'b0000, "en_cfg");
    for (int i = 0; i < 10; i++) step(logic'(i % 2 == 0), 2'b00, 4, 4'b1111, "en_toggle");

    // Asynchronous reset mid-run at run_len 3.
    step(1, 2'b00, 4, 4'b0000, "arst_pre");
    for (int i = 0; i < 3; i++) step(1, 2'b00, 4, 4'b0001, "arst_run");
    #2 rst = 0;
    #1 model_reset();
    check("arst_async");
    #1 rst = 1;
    step(1, 2'b00, 4, 4'b0001, "arst_first");
    tests++;
    assert (bus.run_len[CNT_W-1:0] === 4'd1) else begin
      fails++;
      $error("FAIL arst_first ch0 observed=%0d expected=1", bus.run_len[CNT_W-1:0]);
    end

    // Mode change 00 -> 01 at run_len 5.
    for (int i = 0; i < 4; i++) step(1, 2'b00, 4, 4'b0001, "mchg_ones");
    step(1, 2'b01, 4, 4'b0000, "mchg_edge");
    for (int i = 0; i < 4; i++) step(1, 2'b01, 4, 4'b0000, "mchg_zeros");

    // Random traffic with occasional configuration changes.
    m_r = 0; t_r = 3;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 19) == 0) m_r = int'($urandom_range(0, 3));
      if ($urandom_range(0, 24) == 0) t_r = int'($urandom_range(0, SAT));
      step(logic'($urandom_range(0, 4) != 0), m_r[1:0], t_r,
           CH'($urandom_range(0, 15)), "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
